// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and the default operand width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the execute-stage controller and the
// multiply/divide unit.
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// shift-subtract for divide. {hi,lo} is the accumulator / remainder:quotient pair.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opb} : '0);
    sh   = {hi_in, lo_in[WIDTH-1]};
    diff = sh - {1'b0, opb};
    if (!is_div) begin
      // carry out of the add becomes the new accumulator MSB
      {hi_out, lo_out} = {sum, lo_in[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      hi_out = diff[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], 1'b1};
    end else begin
      hi_out = sh[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO, MTHI/MTLO
// writes and a start/busy/done handshake towards the execute controller.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opb;
  logic               is_div;
  logic               sign_q;
  logic               sign_r;
  logic               dz;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               busy_r;
  logic               done_r;
  logic               dz_r;

  logic               op_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dz_r;

  // Operand magnitudes; the most negative value maps to itself as unsigned.
  always_comb begin
    op_signed = ~bus.op[0];
    a_neg     = op_signed & bus.rs_data[WIDTH-1];
    b_neg     = op_signed & bus.rt_data[WIDTH-1];
    a_mag     = a_neg ? -bus.rs_data : bus.rs_data;
    b_mag     = b_neg ? -bus.rt_data : bus.rt_data;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .hi_in  (acc_hi),
    .lo_in  (acc_lo),
    .opb    (opb),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  always_comb begin
    prod_neg = -{acc_hi, acc_lo};
    res_hi   = acc_hi;
    res_lo   = acc_lo;
    if (dz) begin
      res_hi = acc_hi;
      res_lo = '1;
    end else if (is_div) begin
      if (sign_r) res_hi = -acc_hi;
      if (sign_q) res_lo = -acc_lo;
    end else if (sign_q) begin
      res_hi = prod_neg[2*WIDTH-1:WIDTH];
      res_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      dz     <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            is_div <= bus.op[1];
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            cnt    <= CNT_W'(WIDTH);
            busy_r <= 1'b1;
            acc_hi <= '0;
            // multiply adds rs into the accumulator while shifting rt out;
            // divide shifts rs (dividend) against rt (divisor)
            opb    <= bus.op[1] ? b_mag : a_mag;
            acc_lo <= bus.op[1] ? a_mag : b_mag;
            if (bus.op[1] && (bus.rt_data == '0)) begin
              dz     <= 1'b1;
              acc_hi <= bus.rs_data;
              state  <= SIGN;
            end else begin
              dz     <= 1'b0;
              state  <= CALC;
            end
          end else begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= SIGN;
        end
        SIGN: begin
          hi_r   <= res_hi;
          lo_r   <= res_lo;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          dz_r   <= dz;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Called at a falling edge; returns at the falling edge after the start edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    bus.op = o; bus.rs_data = a; bus.rt_data = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // cyc counts falling edges since the start edge; bounded at 200.
  task automatic wait_done(output int cyc, output int busy_cnt, output logic dz);
    cyc = 1; busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    dz = bus.div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected %h", bus.lo, 32'h0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_multu();
    int cyc, bc; logic dz;
    issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(cyc, bc, dz);
    vectors++; if (cyc !== 34) begin miscompares++; $display("FAIL multu_done_cycle: got %0d expected 34", cyc); end
    vectors++; if (bc !== 33) begin miscompares++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
    vectors++; if (bus.hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h expected %h", bus.hi, 32'hFFFFFFFE); end
    vectors++; if (bus.lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h expected %h", bus.lo, 32'h00000001); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL multu_dbz: got %b expected 0", dz); end
    @(negedge clk);
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL multu_done_width: got %b expected 0", bus.done); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc; logic dz;
    issue(OP_MULT, 32'hFFFFFFFD, 32'h00000007);
    wait_done(cyc, bc, dz);
    vectors++; if (bus.hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h expected %h", bus.hi, 32'hFFFFFFFF); end
    vectors++; if (bus.lo !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_lo: got %h expected %h", bus.lo, 32'hFFFFFFEB); end
    issue(OP_DIV, 32'hFFFFFFF9, 32'h00000002);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: busy got %b expected 1", bus.busy); end
    wait_done(cyc, bc, dz);
    vectors++; if (cyc !== 34) begin miscompares++; $display("FAIL div_done_cycle: got %0d expected 34", cyc); end
    vectors++; if (bus.lo !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL div_lo: got %h expected %h", bus.lo, 32'hFFFFFFFD); end
    vectors++; if (bus.hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL div_hi: got %h expected %h", bus.hi, 32'hFFFFFFFF); end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    int cyc, bc; logic dz;
    issue(OP_DIVU, 32'd100, 32'd0);
    wait_done(cyc, bc, dz);
    vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL dz_done_cycle: got %0d expected 2", cyc); end
    vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b expected 1", dz); end
    vectors++; if (bus.hi !== 32'h00000064) begin miscompares++; $display("FAIL dz_hi: got %h expected %h", bus.hi, 32'h00000064); end
    vectors++; if (bus.lo !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL dz_lo: got %h expected %h", bus.lo, 32'hFFFFFFFF); end
    @(negedge clk);
    vectors++; if (bus.div_by_zero !== 1'b0) begin miscompares++; $display("FAIL dz_flag_width: got %b expected 0", bus.div_by_zero); end
    issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, bc, dz);
    vectors++; if (bus.lo !== 32'h80000000) begin miscompares++; $display("FAIL ovf_lo: got %h expected %h", bus.lo, 32'h80000000); end
    vectors++; if (bus.hi !== 32'h00000000) begin miscompares++; $display("FAIL ovf_hi: got %h expected %h", bus.hi, 32'h00000000); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL ovf_dbz: got %b expected 0", dz); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int cyc, bc; logic dz;
    issue(OP_DIVU, 32'hFFFFFFFF, 32'h00000010);
    repeat (5) @(negedge clk);
    bus.op = OP_MULTU; bus.rs_data = 32'd2; bus.rt_data = 32'd2;
    bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'h00001234;
    @(negedge clk);
    bus.start = 1'b0; bus.hi_we = 1'b0;
    vectors++; if (bus.hi === 32'h00001234) begin miscompares++; $display("FAIL busy_hi_we: got %h expected not %h", bus.hi, 32'h00001234); end
    wait_done(cyc, bc, dz);
    vectors++; if (bus.lo !== 32'h0FFFFFFF) begin miscompares++; $display("FAIL divu_lo: got %h expected %h", bus.lo, 32'h0FFFFFFF); end
    vectors++; if (bus.hi !== 32'h0000000F) begin miscompares++; $display("FAIL divu_hi: got %h expected %h", bus.hi, 32'h0000000F); end
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_ignored: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_idle_writes();
    int cyc, bc; logic dz;
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    vectors++; if (bus.hi !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL mthi: got %h expected %h", bus.hi, 32'hA5A5A5A5); end
    vectors++; if (bus.lo !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL mtlo: got %h expected %h", bus.lo, 32'hA5A5A5A5); end
    bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    issue(OP_MULTU, 32'd3, 32'd4);
    bus.hi_we = 1'b0;
    vectors++; if (bus.hi !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL start_wins_hi: got %h expected %h", bus.hi, 32'hA5A5A5A5); end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL start_wins_busy: got %b expected 1", bus.busy); end
    wait_done(cyc, bc, dz);
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL mul34_hi: got %h expected %h", bus.hi, 32'h0); end
    vectors++; if (bus.lo !== 32'd12) begin miscompares++; $display("FAIL mul34_lo: got %h expected %h", bus.lo, 32'd12); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int cyc, bc; logic dz;
    logic saw_done = 1'b0;
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (9) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    rst = 1'b1;
    #1;
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL midrst_hi: got %h expected %h", bus.hi, 32'h0); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL midrst_lo: got %h expected %h", bus.lo, 32'h0); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    vectors++; if (saw_done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b expected 0", saw_done); end
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_done(cyc, bc, dz);
    vectors++; if (bus.lo !== 32'd30) begin miscompares++; $display("FAIL postrst_lo: got %h expected %h", bus.lo, 32'd30); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL postrst_hi: got %h expected %h", bus.hi, 32'h0); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_data = '0; bus.rt_data = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    rst = 1'b1;
    test_reset();
    test_multu();
    test_back_to_back();
    test_div_by_zero();
    test_ignore_busy();
    test_idle_writes();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the register-file read ports (rs/rt operands) and implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers.
- Also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.
- Multi-cycle: the controller stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a new operation; sampled on clk rising edge
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  input  WIDTH  multiplicand / dividend (register-file data1)
- rt_data  input  WIDTH  multiplier / divisor (register-file data2)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO write data
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_by_zero  output  1  one-cycle pulse with done on a divide by zero

Behaviour:
- Reset (asynchronous, active-high; clk and rst are the only clock/reset ports): hi=0, lo=0, busy=0, done=0, div_by_zero=0, state=IDLE.
- Reset asserted mid-operation aborts the operation immediately; no partial HI/LO update.
- States: IDLE, CALC, SIGN.
- IDLE:
  - start=1 latches op and both operands.
  - Signed ops (MULT/DIV) convert operands to magnitudes and record result signs.
  - Quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs); product sign = XOR.
  - Counter loads WIDTH; go to CALC; busy=1 from the next cycle.
- IDLE with start=0:
  - hi_we loads hi<=wdata; lo_we loads lo<=wdata; both may assert together.
  - If start and hi_we/lo_we coincide, start wins and the writes are dropped.
- CALC: one bit per cycle, exactly WIDTH cycles.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract over a WIDTH-bit remainder/quotient pair.
  - When the counter reaches 0, go to SIGN.
- SIGN:
  - Two's-complement negate the results whose recorded sign is 1.
  - Write HI (product upper / remainder) and LO (product lower / quotient).
  - Go to IDLE; busy drops and done=1 for one cycle.
- Latency: start sampled on edge E0; HI/LO update on edge E(WIDTH+1) (E33 at default); done is high in the cycle after that edge.
- start while busy=1 is ignored. hi_we/lo_we while busy=1 are ignored; the controller must stall.
- start in the done cycle is accepted, so back-to-back operations are allowed.
- Divide by zero (DIV/DIVU with rt_data=0):
  - CALC is skipped; HI/LO update on E1: hi<=rs_data unmodified, lo<=all ones.
  - done=1 and div_by_zero=1 for one cycle.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag.
- Multiply never overflows; the full 2*WIDTH product is kept.
- All arithmetic is modulo 2^WIDTH per half. Magnitude of the most negative value is 0x80000000, treated as unsigned.

Decomposition:
- Shared package mdu_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, CALC, SIGN);
  - the WIDTH default.
- One sub-module, mdu_step: purely combinational single-iteration datapath (add or subtract-compare, plus shift) selected by mul/div.
- The top level holds the FSM, counter, sign flags, operand registers and HI/LO.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles; done pulse in the 34th cycle after start.
- MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); then DIV 0xFFFFFFF9 (-7) / 2 started in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 -> done and div_by_zero pulse in the 2nd cycle; hi=0x00000064, lo=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, no flag.
- DIVU 0xFFFFFFFF / 0x10 with start re-pulsed and hi_we=1 (wdata=0x1234) during CALC -> both ignored; final lo=0x0FFFFFFF, hi=0xF.
- Idle writes: hi_we=1, lo_we=1, wdata=0xA5A5A5A5 -> hi=lo=0xA5A5A5A5. Then start with hi_we=1 in the same cycle -> write dropped, operation runs.
- Reset mid-operation: start MULTU 5 x 6, assert rst 10 cycles later -> hi=lo=0, busy=0, done never pulses. After release, MULTU 5 x 6 -> lo=30, hi=0.
